// File: rtl/spi_bus_bridge_pkg.sv
// Shared definitions for the SPI-to-Xosera-bus bridge:
// command bit positions, idle transmit byte and bridge state encoding.
package spi_bus_bridge_pkg;

  localparam int unsigned SPI_CMD_CS = 7;
  localparam int unsigned SPI_CMD_WR = 6;
  localparam int unsigned SPI_CMD_RS = 5;
  localparam int unsigned SPI_CMD_BS = 4;

  localparam logic [7:0] SPI_IDLE_BYTE = 8'hCB;

  typedef enum logic [1:0] {
    ST_CMD = 2'd0,
    ST_PAY = 2'd1,
    ST_BUS = 2'd2
  } spi_bridge_st_t;

  // A read packet prefetches on its command byte.
  function automatic logic cmd_is_read(input logic [7:0] c);
    return c[SPI_CMD_CS] & ~c[SPI_CMD_WR];
  endfunction

endpackage

// File: rtl/spi_bus_bridge.sv
// SPI byte stream to Xosera register bus bridge.
// Ports: clk, reset_i (sync, active high); select_i/rx_strobe_i/
// rx_byte_i/tx_byte_o to spi_target; bus_*_o/bus_data_i to
// xosera_main; soft_reset_o pulse; overrun_o sticky error.
module spi_bus_bridge
  import spi_bus_bridge_pkg::*;
#(
  parameter int unsigned CS_CYCLES    = 2,
  parameter int unsigned RESET_CYCLES = 1,
  parameter bit          BURST_EN     = 1'b1,
  parameter logic [7:0]  IDLE_BYTE    = SPI_IDLE_BYTE
) (
  input  logic       clk,
  input  logic       reset_i,
  input  logic       select_i,
  input  logic       rx_strobe_i,
  input  logic [7:0] rx_byte_i,
  output logic [7:0] tx_byte_o,
  output logic       bus_cs_n_o,
  output logic       bus_rd_nwr_o,
  output logic       bus_bytesel_o,
  output logic [3:0] bus_reg_num_o,
  output logic [7:0] bus_data_o,
  input  logic [7:0] bus_data_i,
  output logic       soft_reset_o,
  output logic       overrun_o
);

  localparam int unsigned CW =
    (CS_CYCLES > 1) ? $clog2(CS_CYCLES) : 1;
  localparam int unsigned RW = $clog2(RESET_CYCLES + 1);
  localparam logic [CW-1:0] CS_LOAD = CW'(CS_CYCLES - 1);
  localparam logic [RW-1:0] RS_LOAD = RW'(RESET_CYCLES);

  spi_bridge_st_t state_q, state_d;
  logic          cs_en_q, cs_en_d;
  logic          wr_q, wr_d;
  logic [3:0]    reg_q, reg_d;
  logic          bsel_q, bsel_d;
  logic [7:0]    data_q, data_d;
  logic [7:0]    rd_q, rd_d;
  logic          cs_n_q, cs_n_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [RW-1:0] srst_q, srst_d;
  logic          ovr_q, ovr_d;

  logic rd_pkt;
  assign rd_pkt = cs_en_q & ~wr_q;

  always_ff @(posedge clk) begin
    if (reset_i) begin
      state_q <= ST_CMD;
      cs_en_q <= 1'b0;
      wr_q    <= 1'b0;
      reg_q   <= '0;
      bsel_q  <= 1'b0;
      data_q  <= '0;
      rd_q    <= '0;
      cs_n_q  <= 1'b1;
      cnt_q   <= '0;
      srst_q  <= '0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cs_en_q <= cs_en_d;
      wr_q    <= wr_d;
      reg_q   <= reg_d;
      bsel_q  <= bsel_d;
      data_q  <= data_d;
      rd_q    <= rd_d;
      cs_n_q  <= cs_n_d;
      cnt_q   <= cnt_d;
      srst_q  <= srst_d;
      ovr_q   <= ovr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cs_en_d = cs_en_q;
    wr_d    = wr_q;
    reg_d   = reg_q;
    bsel_d  = bsel_q;
    data_d  = data_q;
    rd_d    = rd_q;
    cs_n_d  = cs_n_q;
    cnt_d   = cnt_q;
    srst_d  = srst_q;
    ovr_d   = ovr_q;

    if (srst_q != '0) srst_d = srst_q - 1'b1;

    // Bytes landing inside a bus window are dropped.
    if (rx_strobe_i && state_q == ST_BUS) ovr_d = 1'b1;

    unique case (state_q)
      ST_CMD: begin
        if (select_i && rx_strobe_i) begin
          cs_en_d = rx_byte_i[SPI_CMD_CS];
          wr_d    = rx_byte_i[SPI_CMD_WR];
          reg_d   = rx_byte_i[3:0];
          bsel_d  = rx_byte_i[SPI_CMD_BS];
          if (rx_byte_i[SPI_CMD_RS]) srst_d = RS_LOAD;
          if (cmd_is_read(rx_byte_i)) state_d = ST_BUS;
          else                        state_d = ST_PAY;
        end
      end
      ST_PAY: begin
        if (!select_i) begin
          state_d = ST_CMD;
        end else if (rx_strobe_i) begin
          if (!cs_en_q) begin
            state_d = BURST_EN ? ST_PAY : ST_CMD;
          end else if (!wr_q) begin
            if (BURST_EN) begin
              bsel_d  = ~bsel_q;
              state_d = ST_BUS;
            end else begin
              state_d = ST_CMD;
            end
          end else begin
            data_d  = rx_byte_i;
            state_d = ST_BUS;
          end
        end
      end
      ST_BUS: begin
        // First BUS clock is bus setup with CS still high.
        if (cs_n_q) begin
          cs_n_d = 1'b0;
          cnt_d  = CS_LOAD;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          cs_n_d = 1'b1;
          if (!wr_q)         rd_d   = bus_data_i;
          else if (BURST_EN) bsel_d = ~bsel_q;
          if (!select_i)              state_d = ST_CMD;
          else if (!wr_q || BURST_EN) state_d = ST_PAY;
          else                        state_d = ST_CMD;
        end
      end
      default: state_d = ST_CMD;
    endcase
  end

  assign tx_byte_o     = (state_q != ST_CMD && rd_pkt) ? rd_q : IDLE_BYTE;
  assign bus_cs_n_o    = cs_n_q;
  assign bus_rd_nwr_o  = ~wr_q;
  assign bus_bytesel_o = bsel_q;
  assign bus_reg_num_o = reg_q;
  assign bus_data_o    = data_q;
  assign soft_reset_o  = (srst_q != '0);
  assign overrun_o     = ovr_q;

endmodule

// File: tb/tb_spi_bus_bridge.sv
// Scoreboard bench for spi_bus_bridge.
// Drives a burst DUT (0) and a non-burst DUT (1) from one byte stream.
module tb_spi_bus_bridge;
  import spi_bus_bridge_pkg::*;

  localparam int CSC = 2;

  typedef struct packed {
    logic       rd;
    logic       bs;
    logic [3:0] rg;
    logic [7:0] d;
  } cyc_t;

  logic       clk = 1'b0;
  logic       reset_i = 1'b1;
  logic       select_i = 1'b0;
  logic       rx_strobe_i = 1'b0;
  logic [7:0] rx_byte_i = '0;
  logic [7:0] bus_data_i = '0;

  logic [1:0][7:0] tx;
  logic [1:0]      cs_n, rd_nwr, bsel, srst, ovr;
  logic [1:0][3:0] rg;
  logic [1:0][7:0] dout;

  cyc_t q0[$];
  cyc_t q1[$];
  int nvec = 0;
  int nbad = 0;

  always #5 clk = ~clk;

  spi_bus_bridge #(
    .CS_CYCLES(CSC), .RESET_CYCLES(3), .BURST_EN(1'b1),
    .IDLE_BYTE(8'hCB)
  ) dut_b (
    .clk(clk), .reset_i(reset_i), .select_i(select_i),
    .rx_strobe_i(rx_strobe_i), .rx_byte_i(rx_byte_i),
    .tx_byte_o(tx[0]), .bus_cs_n_o(cs_n[0]),
    .bus_rd_nwr_o(rd_nwr[0]), .bus_bytesel_o(bsel[0]),
    .bus_reg_num_o(rg[0]), .bus_data_o(dout[0]),
    .bus_data_i(bus_data_i), .soft_reset_o(srst[0]),
    .overrun_o(ovr[0])
  );

  spi_bus_bridge #(
    .CS_CYCLES(CSC), .RESET_CYCLES(3), .BURST_EN(1'b0),
    .IDLE_BYTE(8'hCB)
  ) dut_n (
    .clk(clk), .reset_i(reset_i), .select_i(select_i),
    .rx_strobe_i(rx_strobe_i), .rx_byte_i(rx_byte_i),
    .tx_byte_o(tx[1]), .bus_cs_n_o(cs_n[1]),
    .bus_rd_nwr_o(rd_nwr[1]), .bus_bytesel_o(bsel[1]),
    .bus_reg_num_o(rg[1]), .bus_data_o(dout[1]),
    .bus_data_i(bus_data_i), .soft_reset_o(srst[1]),
    .overrun_o(ovr[1])
  );

  task automatic check(input string nm, input int d,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nbad++;
      $display("FAIL %s dut%0d: got %h, want %h", nm, d, act, exp);
    end
  endtask

  function automatic logic [24:0] outs(input int d);
    return {tx[d], cs_n[d], rd_nwr[d], bsel[d], rg[d],
            dout[d], srst[d], ovr[d]};
  endfunction

  localparam logic [24:0] RST_VEC =
    {8'hCB, 1'b1, 1'b1, 1'b0, 4'h0, 8'h00, 1'b0, 1'b0};

  task automatic exp_b(input cyc_t c);
    q0.push_back(c);
  endtask

  task automatic exp_n(input cyc_t c);
    q1.push_back(c);
  endtask

  task automatic exp_both(input cyc_t c);
    q0.push_back(c);
    q1.push_back(c);
  endtask

  // Monitor: on every CS fall pop and compare; on rise check width.
  task automatic mon_start(input int d);
    cyc_t o, e;
    o = '{rd: rd_nwr[d], bs: bsel[d], rg: rg[d], d: dout[d]};
    if (d == 0 && q0.size() > 0)      e = q0.pop_front();
    else if (d == 1 && q1.size() > 0) e = q1.pop_front();
    else begin
      nvec++;
      nbad++;
      $display("FAIL unexpected_cycle dut%0d: got %h, want none",
               d, o);
      return;
    end
    if (e.rd) o.d = e.d;
    check("bus_cycle", d, 32'(o), 32'(e));
  endtask

  logic [1:0] prev_cs = 2'b11;
  int lowcnt[2];

  always @(posedge clk) begin
    #1;
    for (int d = 0; d < 2; d++) begin
      if (reset_i) begin
        lowcnt[d] = 0;
      end else if (prev_cs[d] && !cs_n[d]) begin
        lowcnt[d] = 1;
        mon_start(d);
      end else if (!cs_n[d]) begin
        lowcnt[d]++;
      end else if (!prev_cs[d]) begin
        check("cs_width", d, 32'(lowcnt[d]), 32'(CSC));
      end
      prev_cs[d] = cs_n[d];
    end
  end

  task automatic clocks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse(input logic [7:0] b);
    rx_strobe_i = 1'b1;
    rx_byte_i   = b;
    @(negedge clk);
    rx_strobe_i = 1'b0;
  endtask

  task automatic send(input logic [7:0] b);
    pulse(b);
    clocks(6);
  endtask

  task automatic sel(input logic s);
    select_i = s;
    clocks(2);
  endtask

  initial begin
    logic [1:0][3:0] sr;
    clocks(3);
    for (int d = 0; d < 2; d++)
      check("reset_state", d, 32'(outs(d)), 32'(RST_VEC));
    reset_i = 1'b0;
    clocks(2);

    // Write, non-burst vs burst on the same stream.
    sel(1'b1);
    send(8'hC3);
    exp_both('{rd: 1'b0, bs: 1'b0, rg: 4'h3, d: 8'h5A});
    send(8'h5A);
    exp_b('{rd: 1'b0, bs: 1'b1, rg: 4'h3, d: 8'hC4});
    send(8'hC4);
    exp_b('{rd: 1'b0, bs: 1'b0, rg: 4'h3, d: 8'h77});
    exp_n('{rd: 1'b0, bs: 1'b0, rg: 4'h4, d: 8'h77});
    send(8'h77);
    sel(1'b0);

    // Write burst.
    sel(1'b1);
    send(8'hD1);
    exp_both('{rd: 1'b0, bs: 1'b1, rg: 4'h1, d: 8'h12});
    send(8'h12);
    exp_b('{rd: 1'b0, bs: 1'b0, rg: 4'h1, d: 8'h34});
    send(8'h34);
    exp_b('{rd: 1'b0, bs: 1'b1, rg: 4'h1, d: 8'h56});
    send(8'h56);
    sel(1'b0);

    // Read burst with prefetch.
    sel(1'b1);
    bus_data_i = 8'hA0;
    for (int d = 0; d < 2; d++)
      check("tx_cmd", d, 32'(tx[d]), 32'hCB);
    exp_both('{rd: 1'b1, bs: 1'b0, rg: 4'h2, d: 8'h00});
    send(8'h82);
    for (int d = 0; d < 2; d++)
      check("tx_pay1", d, 32'(tx[d]), 32'hA0);
    bus_data_i = 8'hA1;
    exp_b('{rd: 1'b1, bs: 1'b1, rg: 4'h2, d: 8'h00});
    send(8'h00);
    check("tx_pay2", 0, 32'(tx[0]), 32'hA1);
    check("tx_after", 1, 32'(tx[1]), 32'hCB);
    bus_data_i = 8'hA2;
    exp_b('{rd: 1'b1, bs: 1'b0, rg: 4'h2, d: 8'h00});
    send(8'h00);
    sel(1'b0);

    // Soft reset, then a no-op packet.
    sel(1'b1);
    pulse(8'h20);
    for (int i = 0; i < 4; i++) begin
      sr[0][i] = srst[0];
      sr[1][i] = srst[1];
      clocks(1);
    end
    for (int d = 0; d < 2; d++)
      check("soft_reset", d, 32'(sr[d]), 32'h7);
    clocks(4);
    sel(1'b0);
    sel(1'b1);
    send(8'h00);
    send(8'h99);
    sel(1'b0);

    // Deselect between command and payload.
    sel(1'b1);
    send(8'hC5);
    sel(1'b0);
    sel(1'b1);
    exp_both('{rd: 1'b0, bs: 1'b0, rg: 4'h6, d: 8'h3C});
    send(8'hC6);
    send(8'h3C);
    sel(1'b0);

    // Overrun: strobes one clock apart.
    for (int d = 0; d < 2; d++)
      check("ovr_clear", d, 32'(ovr[d]), 32'h0);
    sel(1'b1);
    send(8'hC7);
    exp_both('{rd: 1'b0, bs: 1'b0, rg: 4'h7, d: 8'h11});
    pulse(8'h11);
    pulse(8'h22);
    clocks(6);
    for (int d = 0; d < 2; d++)
      check("ovr_set", d, 32'(ovr[d]), 32'h1);
    exp_b('{rd: 1'b0, bs: 1'b1, rg: 4'h7, d: 8'h33});
    send(8'h33);
    for (int d = 0; d < 2; d++)
      check("ovr_sticky", d, 32'(ovr[d]), 32'h1);
    sel(1'b0);

    // Reset in the middle of a CS window.
    sel(1'b1);
    send(8'hC8);
    exp_both('{rd: 1'b0, bs: 1'b0, rg: 4'h8, d: 8'h44});
    pulse(8'h44);
    clocks(1);
    for (int d = 0; d < 2; d++)
      check("cs_low_pre", d, 32'(cs_n[d]), 32'h0);
    reset_i = 1'b1;
    clocks(1);
    for (int d = 0; d < 2; d++)
      check("mid_reset", d, 32'(outs(d)), 32'(RST_VEC));
    reset_i = 1'b0;
    clocks(1);
    exp_both('{rd: 1'b0, bs: 1'b0, rg: 4'h9, d: 8'h55});
    send(8'hC9);
    send(8'h55);
    sel(1'b0);
    clocks(4);

    check("queue_empty", 0, 32'(q0.size()), 32'h0);
    check("queue_empty", 1, 32'(q1.size()), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end

endmodule

// File: doc/spi_bus_bridge.md
# spi_bus_bridge

Parametrised SPI-to-Xosera-bus bridge. It replaces the inline two-byte SPI command decoder in the iCEBreaker top with a reusable block. It sits between `spi_target` (byte stream) and `xosera_main` (register bus), turning command/payload byte packets into timed bus cycles. Over the fixed cmd+1-byte scheme it adds:
- burst packets with automatic byte-select toggling,
- read prefetch, so read data is ready before its SPI byte shifts out,
- a configurable CS width and soft-reset pulse,
- a sticky overrun error flag.

## Interface
Parameters:
- `CS_CYCLES`, 2: clocks `bus_cs_n_o` is held low per bus cycle (≥1).
- `RESET_CYCLES`, 1: clocks `soft_reset_o` is held high per RS command (≥1).
- `BURST_EN`, 1: 1 = payload bytes continue until deselect; 0 = exactly one payload byte per command.
- `IDLE_BYTE`, 8'hCB: transmit byte outside payload phase.

Ports:
- `clk`  in  1  pixel clock (single clock domain).
- `reset_i`  in  1  synchronous, active-high reset.
- `select_i`  in  1  SPI target selected (from `spi_target`).
- `rx_strobe_i`  in  1  one-clock pulse: received byte valid.
- `rx_byte_i`  in  8  received byte.
- `tx_byte_o`  out  8  byte for `spi_target` to shift out next.
- `bus_cs_n_o`  out  1  bus select, active low.
- `bus_rd_nwr_o`  out  1  1 = read, 0 = write.
- `bus_bytesel_o`  out  1  0 = even byte, 1 = odd byte.
- `bus_reg_num_o`  out  4  register number.
- `bus_data_o`  out  8  write data to `xosera_main`.
- `bus_data_i`  in  8  read data from `xosera_main`.
- `soft_reset_o`  out  1  soft-reset request.
- `overrun_o`  out  1  sticky error: byte arrived during a bus cycle.

## Operation
- Command byte bits, MSB to LSB: CS, WR, RS, BS, R3..R0.
  - CS = 0: no-op packet; payload bytes are discarded.
  - RS = 1: pulse `soft_reset_o`.
- States: CMD (awaiting command), PAY (awaiting payload), BUS (CS window active).
  - CMD → PAY on `rx_strobe_i`: latch command, set `bytesel_q` = BS.
  - PAY → BUS on `rx_strobe_i`, when CS = 1.
  - BUS → PAY after `CS_CYCLES` clocks, if `BURST_EN` = 1.
  - BUS → CMD after `CS_CYCLES` clocks, if `BURST_EN` = 0.
  - `select_i` low in any state → CMD. An active BUS window always completes first.
- Write packet: each payload byte latches `bus_data_o` and issues one write cycle. After each cycle, `bytesel_q` toggles when `BURST_EN` = 1.
- Read packet:
  - Receipt of the command byte launches a read cycle (prefetch).
  - `bus_data_i` is captured into `rd_q` on the last CS-low clock.
  - With `BURST_EN` = 1, each payload byte toggles `bytesel_q` and launches the next prefetch read.
  - With `BURST_EN` = 0, no read is issued after the single payload byte.
- `tx_byte_o` = `rd_q` during PAY/BUS of a read packet, else `IDLE_BYTE`.
- `bus_reg_num_o` and `bus_rd_nwr_o` follow the latched command for the whole packet. The register number is never auto-incremented.
- Overrun: `rx_strobe_i` while in BUS sets `overrun_o`. The byte is dropped and the current cycle completes unchanged. Only `reset_i` clears `overrun_o`.

## Timing
- Reset values:
  - `bus_cs_n_o`=1, `bus_rd_nwr_o`=1, `bus_bytesel_o`=0, `bus_reg_num_o`=0.
  - `bus_data_o`=0, `rd_q`=0, `tx_byte_o`=`IDLE_BYTE`.
  - `soft_reset_o`=0, `overrun_o`=0, state = CMD.
- Bus cycle start: `bus_cs_n_o` falls on the clock after the triggering `rx_strobe_i`, and stays low exactly `CS_CYCLES` clocks.
- Bus signal stability: data, reg, rd_nwr and bytesel are valid one clock before CS falls, and stable until CS rises.
- Read data: `rd_q` is valid `CS_CYCLES`+1 clocks after the strobe.
- Minimum byte spacing: `CS_CYCLES`+2 clocks.
- `soft_reset_o` rises the clock after the command strobe and holds `RESET_CYCLES` clocks. It is independent of packet state.
- `reset_i` mid-cycle:
  - all outputs return to reset values on the next clock;
  - a partial packet is abandoned;
  - the next received byte is treated as a command.

## Structure
- Add to package `xv`:
  - command bit-position constants `SPI_CMD_CS`/`WR`/`RS`/`BS`;
  - `SPI_IDLE_BYTE`;
  - a state enum `spi_bridge_st_t`.
- No sub-module. `spi_target` stays external.
- The top instantiates the bridge under `SPI_INTERFACE` and ORs `soft_reset_o` into its reset flop.

## Test plan
- Write, non-burst: cmd 8'hC3, payload 8'h5A → one cycle: cs_n low 2 clocks, reg 3, rd_nwr 0, bytesel 0, data 8'h5A; next byte decoded as command.
- Write burst: cmd 8'hD1, payloads 8'h12, 8'h34, 8'h56 → three cycles on reg 1, bytesel 1, 0, 1, matching data each.
- Read burst: cmd 8'h82, `bus_data_i` = 8'hA0, 8'hA1 per cycle → `tx_byte_o` = 8'hCB during the command byte, then 8'hA0, 8'hA1 on successive payloads; bytesel 0, 1, 0.
- Soft reset with `RESET_CYCLES`=3: cmd 8'h20 → `soft_reset_o` high 3 clocks, no bus cycle; cmd 8'h00 + payload → no bus cycle.
- Overrun: strobes 1 clock apart in PAY → `overrun_o`=1, single CS window, sticky until `reset_i`.
- Boundaries:
  - `select_i` drop between command and payload → state CMD;
  - `reset_i` mid-CS → cs_n=1 next clock, all outputs at reset values.
